// File: rtl/fp32_pkg.sv
// Shared fp32 types for the multiplier result path.
package fp32_pkg;
  localparam int FP32_W = 32;
  localparam logic [7:0] FP32_EXP_MAX = 8'hFF;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
  } fp_flags_t;

  typedef struct packed {
    fp_flags_t         flags;
    logic [FP32_W-1:0] data;
  } fp32_entry_t;
endpackage

// File: rtl/fp_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head reads as zero when empty.
module fp_sync_fifo
  import fp32_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = fp32_entry_t,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        push_i,
  input  T            wdata_i,
  input  logic        pop_i,
  output T            rdata_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] occ_o
);
  T              mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          do_push, do_pop;

  assign empty_o = (occ_q == '0);
  assign full_o  = (occ_q == (AW+1)'(DEPTH));
  assign occ_o   = occ_q;
  assign rdata_o = empty_o ? T'('0) : mem[rptr_q];

  // A pop frees the slot first, so push+pop is legal when full; no bypass when empty.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop)      occ_d = occ_q + 1'b1;
    else if (!do_push && do_pop) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && do_push) mem[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/fp32_result_collector.sv
// Buffers fp32 multiplier results, tracks sticky flags/count and hands out issue credits.
module fp32_result_collector
  import fp32_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             issue_i,
  output logic             issue_ok_o,
  input  logic             done_i,
  input  logic [31:0]      result_i,
  input  logic             overflow_i,
  input  logic             underflow_i,
  input  logic             invalid_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [31:0]      m_data_o,
  output logic [2:0]       m_flags_o,
  output logic [2:0]       sticky_flags_o,
  input  logic             clear_flags_i,
  output logic [CNT_W-1:0] count_o,
  output logic             err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW+1:0] DEPTH_CW = (AW+2)'(DEPTH);

  fp32_entry_t      wentry, head;
  logic             full, empty, pop, push_acc;
  logic [AW:0]      occ;
  logic [AW:0]      in_flight_q, in_flight_d;
  logic [AW+1:0]    committed;
  fp_flags_t        sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  assign wentry.flags.invalid   = invalid_i;
  assign wentry.flags.overflow  = overflow_i;
  assign wentry.flags.underflow = underflow_i;
  assign wentry.data            = result_i;

  assign pop      = m_valid_o && m_ready_i;
  assign push_acc = done_i && (!full || pop);

  fp_sync_fifo #(.DEPTH(DEPTH), .T(fp32_entry_t)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (done_i),
    .wdata_i (wentry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .occ_o   (occ)
  );

  assign m_valid_o = !empty;
  assign m_data_o  = head.data;
  assign m_flags_o = head.flags;

  // Widened sum so a protocol-error overcommit cannot wrap into a false credit.
  assign committed  = {1'b0, occ} + {1'b0, in_flight_q};
  assign issue_ok_o = (committed < DEPTH_CW);

  always_comb begin
    in_flight_d = in_flight_q;
    if (issue_i && !done_i) begin
      if (in_flight_q != DEPTH_C) in_flight_d = in_flight_q + 1'b1;
    end else if (!issue_i && done_i) begin
      if (in_flight_q != '0) in_flight_d = in_flight_q - 1'b1;
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    if (push_acc)           sticky_d = clear_flags_i ? wentry.flags : (sticky_q | wentry.flags);
    else if (clear_flags_i) sticky_d = '0;
  end

  always_comb begin
    count_d = push_acc ? count_q + 1'b1 : count_q;
    err_d   = err_q
            | (done_i && !push_acc)
            | (done_i && in_flight_q == '0)
            | (issue_i && !issue_ok_o);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      in_flight_q <= '0;
      sticky_q    <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      sticky_q    <= sticky_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign sticky_flags_o = sticky_q;
  assign count_o        = count_q;
  assign err_o          = err_q;
endmodule

// File: doc/fp32_result_collector.md
Name: fp32_result_collector

Overview:
- Downstream stage of fp32Multiplier. Captures each result_o/flag set on done_o into an elastic FIFO and presents it on a ready/valid master interface.
- Accumulates sticky IEEE exception flags and counts completed results.
- Returns issue credits so the upstream driver never has more multiplies in flight than free FIFO slots. This keeps a pipeline with no backpressure lossless.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the completed-result counter.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- issue_i  in  1  upstream asserts valid_i into the multiplier this cycle; consumes one credit
- issue_ok_o  out  1  at least one credit free; upstream may issue this cycle
- done_i  in  1  multiplier done_o
- result_i  in  32  multiplier result_o
- overflow_i  in  1  multiplier overflow_o
- underflow_i  in  1  multiplier underflow_o
- invalid_i  in  1  multiplier invalid_o
- m_valid_o  out  1  FIFO head valid
- m_ready_i  in  1  downstream accepts head
- m_data_o  out  32  head result
- m_flags_o  out  3  head flags {invalid, overflow, underflow}
- sticky_flags_o  out  3  OR of all pushed flags since reset/clear
- clear_flags_i  in  1  clears sticky_flags_o
- count_o  out  CNT_W  results pushed since reset; wraps
- err_o  out  1  sticky protocol error: push while full, or done_i with zero in-flight

Behaviour:
- Reset: all of the following are 0 on the first edge with rstn low:
  - pointers, occupancy, in_flight
  - m_valid_o, m_data_o, m_flags_o
  - sticky_flags_o, count_o, err_o
- Reset: issue_ok_o is 1 after reset. Inputs are ignored while rstn is low.
- Reset mid-operation discards buffered and in-flight entries. The multiplier is reset in the same cycle.
- FIFO is first-word fall-through. m_data_o and m_flags_o show the head entry whenever m_valid_o=1, and are held stable until the handshake.
- Pop occurs when m_valid_o and m_ready_i are both high. m_valid_o=1 iff occupancy>0.
- Push occurs on done_i. Latency is one cycle: the entry is visible at the head on the edge after done_i when the FIFO was empty.
- Simultaneous push and pop:
  - occupancy unchanged.
  - Legal when full, because the pop frees the slot first.
  - When empty, only the push takes effect (no bypass).
- Push when full without a pop: entry dropped, err_o set, count_o not incremented.
- Credits: credits = DEPTH - occupancy - in_flight. issue_ok_o = (credits != 0), computed from registered state only.
- in_flight next = in_flight + issue_i - done_i. Simultaneous issue_i and done_i leaves it unchanged.
- issue_i while issue_ok_o=0 is a protocol error: sets err_o, and the counter saturates at DEPTH.
- done_i while in_flight=0 sets err_o. The push still proceeds if space is free.
- Sticky flags: sticky_flags_o |= pushed flags on each push. clear_flags_i zeroes them, but a push in the same cycle wins and leaves only that entry's flags.
- count_o increments by 1 per accepted push and wraps modulo 2^CNT_W.
- err_o is cleared only by reset.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits.

Decomposition:
- Package fp32_pkg holds:
  - typedef fp_flags_t, a packed struct {invalid, overflow, underflow}.
  - constants FP32_W=32, FP32_EXP_MAX=8'hFF.
  - typedef fp32_entry_t = {fp_flags_t, logic[31:0]}.
- One sub-module, fp_sync_fifo (DEPTH, type of fp32_entry_t): FWFT storage with full and empty outputs.
- Credit logic, sticky flags, counter and error logic stay in the top module.

Test Plan:
- Single result: after reset, issue_i for 1 cycle, then done_i with result_i=32'h40C00000 and flags 000; m_ready_i=1 → m_valid_o for 1 cycle with m_data_o=40C00000; count_o=1; sticky=000; issue_ok_o=1 throughout.
- Credit exhaustion (DEPTH=8), m_ready_i=0: issue 8 back-to-back → issue_ok_o=0 after the 8th. Return 8 done_i → occupancy 8, m_valid_o=1, issue_ok_o still 0. One pop → issue_ok_o=1 the next cycle.
- Push/pop when full: FIFO full, done_i and pop in the same cycle → occupancy stays 8, no err_o, entries come out in push order.
- Sticky flags:
  - push 7F800000 with overflow=1, then 7FC00000 with invalid=1 → sticky_flags_o=3'b110.
  - clear_flags_i together with a push of underflow=1 → sticky=3'b001.
- Errors:
  - done_i with in_flight=0 → err_o=1, entry still pushed.
  - full FIFO with done_i and no pop → entry dropped, count_o unchanged.
- Reset mid-stream: 5 entries buffered, 3 in flight, rstn low for 1 cycle → m_valid_o=0, count_o=0, issue_ok_o=1, sticky=000.
